// File: rtl/regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_if
// Purpose  : Write-back bus and dual read-port bundle for the register file.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wr_enable;
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] wr_data;
  logic              rd1_enable;
  logic [ADDR_W-1:0] rd1_address;
  logic [DATA_W-1:0] rd1_data;
  logic              rd2_enable;
  logic [ADDR_W-1:0] rd2_address;
  logic [DATA_W-1:0] rd2_data;

  modport master (
    output wr_enable, wr_address, wr_data,
    output rd1_enable, rd1_address,
    output rd2_enable, rd2_address,
    input  rd1_data, rd2_data
  );

  modport slave (
    input  wr_enable, wr_address, wr_data,
    input  rd1_enable, rd1_address,
    input  rd2_enable, rd2_address,
    output rd1_data, rd2_data
  );
endinterface
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile
// Purpose  : 32x32 MIPS register file, one write port, two bypassed reads.
// Revision : 1.0 - initial release
// ============================================================================
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  regfile_if.slave  bus
);
  localparam int c_depth = 2 ** ADDR_W;

  // Entry 0 has no storage; address 0 is resolved to zero on the read side.
  logic [DATA_W-1:0] r_regs [1:c_depth-1];
  logic [DATA_W-1:0] w_rd1_data;
  logic [DATA_W-1:0] w_rd2_data;

  // Per-entry equality decode: an unknown address never matches, so no entry is hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < c_depth; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < c_depth; i++) begin
        if (bus.wr_enable && (bus.wr_address == ADDR_W'(i))) begin
          r_regs[i] <= bus.wr_data;
        end
      end
    end
  end

  always_comb begin
    w_rd1_data = '0;
    if (rst_n && bus.rd1_enable && (bus.rd1_address != '0)) begin
      if (bus.wr_enable && (bus.wr_address == bus.rd1_address)) begin
        w_rd1_data = bus.wr_data;
      end else begin
        w_rd1_data = r_regs[bus.rd1_address];
      end
    end
  end

  always_comb begin
    w_rd2_data = '0;
    if (rst_n && bus.rd2_enable && (bus.rd2_address != '0)) begin
      if (bus.wr_enable && (bus.wr_address == bus.rd2_address)) begin
        w_rd2_data = bus.wr_data;
      end else begin
        w_rd2_data = r_regs[bus.rd2_address];
      end
    end
  end

  assign bus.rd1_data = w_rd1_data;
  assign bus.rd2_data = w_rd2_data;
endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile
// Purpose  : Directed self-checking bench for regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.wr_enable  = en;
    bus.wr_address = a;
    bus.wr_data    = d;
  endtask

  task automatic rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    bus.rd1_enable  = e1;
    bus.rd1_address = a1;
    bus.rd2_enable  = e2;
    bus.rd2_address = a2;
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    wr(1'b0, 5'd0, 32'h0);
    rd(1'b0, 5'd0, 1'b0, 5'd0);
    check("reset_rd1", bus.rd1_data, 32'h0);
    check("reset_rd2", bus.rd2_data, 32'h0);

    // Reset overrides the bypass path as well
    wr(1'b1, 5'd5, 32'hCAFE0001);
    rd(1'b1, 5'd5, 1'b1, 5'd5);
    check("reset_no_bypass", bus.rd1_data, 32'h0);
    tick();
    rst_n = 1'b1;
    wr(1'b0, 5'd0, 32'h0);
    rd(1'b1, 5'd5, 1'b0, 5'd0);
    check("reset_edge_write_dropped", bus.rd1_data, 32'h0);

    // Reset clear, asynchronous
    wr(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rd(1'b1, 5'd5, 1'b0, 5'd0);
    check("r5_written", bus.rd1_data, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    check("async_clear_immediate", bus.rd1_data, 32'h0);
    #1 rst_n = 1'b1;
    #1;
    check("r5_after_release", bus.rd1_data, 32'h0);
    tick();
    check("r5_after_edge", bus.rd1_data, 32'h0);

    // Basic write/read
    wr(1'b1, 5'd1, 32'h00000011);
    tick();
    wr(1'b1, 5'd31, 32'hFFFFFFFF);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rd(1'b1, 5'd1, 1'b1, 5'd31);
    check("rd1_r1", bus.rd1_data, 32'h00000011);
    check("rd2_r31", bus.rd2_data, 32'hFFFFFFFF);
    for (int a = 0; a < 32; a++) begin
      if (a != 1 && a != 31) begin
        rd(1'b1, 5'(a), 1'b1, 5'(31 - a));
        check($sformatf("others_zero_r%0d", a), bus.rd1_data, 32'h0);
      end
    end

    // $0 hardwire
    wr(1'b1, 5'd0, 32'h12345678);
    rd(1'b1, 5'd0, 1'b1, 5'd0);
    check("r0_during_write_rd1", bus.rd1_data, 32'h0);
    check("r0_during_write_rd2", bus.rd2_data, 32'h0);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rd(1'b1, 5'd0, 1'b0, 5'd0);
    check("r0_after_edge", bus.rd1_data, 32'h0);

    // Same-cycle bypass on both ports
    wr(1'b1, 5'd7, 32'h0000AAAA);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rd(1'b1, 5'd7, 1'b1, 5'd7);
    check("r7_initial", bus.rd1_data, 32'h0000AAAA);
    wr(1'b1, 5'd7, 32'h0000BBBB);
    rd(1'b1, 5'd7, 1'b1, 5'd7);
    check("bypass_rd1", bus.rd1_data, 32'h0000BBBB);
    check("bypass_rd2", bus.rd2_data, 32'h0000BBBB);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rd(1'b1, 5'd7, 1'b1, 5'd7);
    check("r7_stored_rd1", bus.rd1_data, 32'h0000BBBB);
    check("r7_stored_rd2", bus.rd2_data, 32'h0000BBBB);

    // Read enable gating
    wr(1'b1, 5'd3, 32'h00000033);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rd(1'b1, 5'd3, 1'b0, 5'd3);
    check("gate_rd1_r3", bus.rd1_data, 32'h00000033);
    check("gate_rd2_off", bus.rd2_data, 32'h0);

    // Mixed: port 1 from storage, port 2 bypassing a different register
    wr(1'b1, 5'd3, 32'h00000077);
    rd(1'b1, 5'd1, 1'b1, 5'd3);
    check("mixed_rd1_storage", bus.rd1_data, 32'h00000011);
    check("mixed_rd2_bypass", bus.rd2_data, 32'h00000077);
    tick();

    // Write suppression
    wr(1'b1, 5'd9, 32'h0000005A);
    tick();
    wr(1'b0, 5'd9, 32'h00000099);
    rd(1'b1, 5'd9, 1'b0, 5'd0);
    for (int e = 0; e < 4; e++) begin
      check($sformatf("suppress_no_bypass_%0d", e), bus.rd1_data, 32'h0000005A);
      tick();
    end
    check("suppress_r9_kept", bus.rd1_data, 32'h0000005A);

    // Write coinciding with reset is discarded, array stays clear
    wr(1'b1, 5'd2, 32'h00000022);
    #1 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wr(1'b0, 5'd0, 32'h0);
    rd(1'b1, 5'd2, 1'b1, 5'd1);
    check("reset_write_discarded", bus.rd1_data, 32'h0);
    check("reset_cleared_r1", bus.rd2_data, 32'h0);

    // Write on the deassertion edge is performed
    rst_n = 1'b0;
    wr(1'b1, 5'd4, 32'h00000044);
    #2 rst_n = 1'b1;
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rd(1'b1, 5'd4, 1'b0, 5'd0);
    check("release_edge_write", bus.rd1_data, 32'h00000044);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regfile.md
# regfile

General-purpose register file for the Jahangir MIPS32 pipeline: the consuming end of the write-back path driven by stage 4. It holds 32 × 32-bit architectural registers. It accepts one write per clock from the write-back bus (`wr_data`, `wr_address`, `wr_enable`) and serves two independent combinational read ports to the decode stage. It hardwires `$0`, and bypasses a same-cycle write to a matching read.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, register index width (depth = 2**ADDR_W = 32)
- `clk`  input  1  system clock; all state updates on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `wr_enable`  input  1  write request from write-back bus
- `wr_address`  input  ADDR_W  destination register index
- `wr_data`  input  DATA_W  value to write
- `rd1_enable`  input  1  read port 1 request
- `rd1_address`  input  ADDR_W  read port 1 index
- `rd1_data`  output  DATA_W  read port 1 value
- `rd2_enable`  input  1  read port 2 request
- `rd2_address`  input  ADDR_W  read port 2 index
- `rd2_data`  output  DATA_W  read port 2 value

## Operation
- Storage: 32 entries × DATA_W flops. Entry 0 is never written; it always reads 0.
- Write: on a rising `clk` edge with `rst_n`=1, `wr_enable`=1 and `wr_address`≠0, `regs[wr_address]` ← `wr_data`.
  - `wr_address`=0 with `wr_enable`=1 is silently dropped.
  - `wr_enable`=0 leaves all entries unchanged.
- Read, evaluated independently for each port (p = 1, 2), in priority order:
  1. `rst_n`=0 → `rdp_data` = 0.
  2. `rdp_enable`=0 → 0.
  3. `rdp_address`=0 → 0.
  4. `wr_enable`=1 and `wr_address`==`rdp_address` → `wr_data` (write-through bypass, so decode sees the value stage 4 retires this cycle).
  5. Otherwise → `regs[rdp_address]`.
- Both ports may address the same register, and the write target, at once. Each port resolves identically and both may bypass simultaneously.
- Reset: asserting `rst_n`=0 clears all 32 entries to 0 immediately, without waiting for `clk`. It also forces both read outputs to 0.
  - Deassertion takes effect at the next rising edge: a write presented on that edge is performed.
- Reset mid-operation: a write whose edge coincides with `rst_n`=0 is discarded. The array stays all-zero.

## Timing
- Write latency: 1 clock. Data presented before edge N is stored at edge N and readable from storage after edge N.
- Read latency: 0 clocks, purely combinational from `rdp_enable`/`rdp_address`, `wr_*`, and `regs`.
- Bypass path is combinational: `wr_data` → `rdp_data` in the same cycle. Timing closure must budget stage-4 output → decode read.
- No handshake or backpressure: the write port is accepted unconditionally every cycle, and reads never stall.
- Reset values: `rd1_data`=0, `rd2_data`=0, all `regs`=0.
- X handling: `rdp_address` or `wr_address` containing X must not corrupt other entries in simulation. Writes are gated on a fully known address.

## Test plan
- Reset clear: write 0xDEADBEEF to r5, then pulse `rst_n` low mid-cycle (asynchronously) → `rd1_data` reads 0 at r5 immediately. After release, r5 reads 0 with no write.
- Basic write/read: write r1=0x00000011, r31=0xFFFFFFFF on consecutive edges, with `wr_enable`=0 afterwards → rd1@r1 = 0x00000011, rd2@r31 = 0xFFFFFFFF, and all other registers read 0.
- `$0` hardwire: write r0=0x12345678 → rd1@r0 = 0 both during the write cycle (no bypass) and after the edge.
- Same-cycle bypass: r7 holds 0x0000AAAA; drive `wr_enable`=1, r7 ← 0x0000BBBB, with rd1@r7 and rd2@r7 enabled → both read 0x0000BBBB before the edge and after it.
- Read enable gating: r3=0x00000033, `rd2_enable`=0 with `rd2_address`=3 → `rd2_data`=0, while rd1@r3 = 0x00000033.
- Write suppression: `wr_enable`=0 with `wr_address`=9, `wr_data`=0x99 for 4 edges → r9 stays at its prior value. Concurrently, rd1@r9 does not bypass.
